id_stage_ctrl: RTL

ID_STAGE_CTRL -- requirements
Module: id_stage_ctrl

---
 rtl/id_stage_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/id_stage_ctrl.sv
// ID-stage control: opcode decode into the ID/EX register, load-use hazard stall, bubble counter.
// Optional macro ID_MULDIV_EN: flags M-extension R-type instructions on mul_o.
module id_stage_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       instr_i,
  input  logic              valid_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              branch_o,
  output logic              alusrc_o,
  output logic              regwrite_o,
  output logic              memread_o,
  output logic              memwrite_o,
  output logic              memtoreg_o,
  output logic              jump_o,
  output logic [1:0]        aluop_o,
  output logic [REG_AW-1:0] rs1_o,
  output logic [REG_AW-1:0] rs2_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              valid_o,
  output logic              mul_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_BUBBLE = 1'b1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [0:0]        state_q, state_d;
  logic              branch_q, branch_d;
  logic              alusrc_q, alusrc_d;
  logic              regwrite_q, regwrite_d;
  logic              memread_q, memread_d;
  logic              memwrite_q, memwrite_d;
  logic              memtoreg_q, memtoreg_d;
  logic              jump_q, jump_d;
  logic [1:0]        aluop_q, aluop_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rs2_q, rs2_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              valid_q, valid_d;
  logic              mul_q, mul_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [6:0]        opcode;
  logic              dec_branch, dec_alusrc, dec_regwrite, dec_memread;
  logic              dec_memwrite, dec_jump, dec_mul;
  logic [1:0]        dec_aluop;
  logic [REG_AW-1:0] src1, src2;
  logic              hit;
  logic              unused_bits;

  assign opcode      = instr_i[6:0];
  assign src1        = instr_i[15 +: REG_AW];
  assign src2        = instr_i[20 +: REG_AW];
  assign unused_bits = ^{instr_i[14:12], instr_i[31:25]};

  always_comb begin
    dec_regwrite = !((opcode == OP_STORE) || (opcode == OP_BRANCH));
    dec_branch   = (opcode == OP_BRANCH);
    dec_memread  = (opcode == OP_LOAD);
    dec_memwrite = (opcode == OP_STORE);
    dec_jump     = instr_i[2];
    dec_alusrc   = (opcode[6:5] == 2'b00) || (opcode[6:4] == 3'b010);
    if (opcode[6:5] == 2'b11)      dec_aluop = 2'b01;
    else if (opcode[5:4] == 2'b11) dec_aluop = 2'b10;
    else if (opcode[4])            dec_aluop = 2'b11;
    else                           dec_aluop = 2'b00;
`ifdef ID_MULDIV_EN
    dec_mul = (opcode == OP_REG) && (instr_i[31:25] == 7'b0000001);
`else
    dec_mul = 1'b0;
`endif
  end

  // A load in EX whose destination feeds this instruction; the BUBBLE state
  // blocks a second stall on the same load.
  assign hit = valid_q && memread_q && (rd_q != '0) &&
               ((rd_q == src1) || (rd_q == src2)) && valid_i &&
               (state_q == ST_RUN);
  assign stall_o = hit && !flush_i;

  always_comb begin
    branch_d   = 1'b0;
    alusrc_d   = 1'b0;
    regwrite_d = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    memtoreg_d = 1'b0;
    jump_d     = 1'b0;
    aluop_d    = 2'b00;
    rs1_d      = '0;
    rs2_d      = '0;
    rd_d       = '0;
    valid_d    = 1'b0;
    mul_d      = 1'b0;
    if (!flush_i && !stall_o && valid_i) begin
      branch_d   = dec_branch;
      alusrc_d   = dec_alusrc;
      regwrite_d = dec_regwrite;
      memread_d  = dec_memread;
      memwrite_d = dec_memwrite;
      memtoreg_d = dec_memread;
      jump_d     = dec_jump;
      aluop_d    = dec_aluop;
      rs1_d      = src1;
      rs2_d      = src2;
      rd_d       = instr_i[7 +: REG_AW];
      valid_d    = 1'b1;
      mul_d      = dec_mul;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_o && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d = ST_RUN;
    if ((state_q == ST_RUN) && stall_o) state_d = ST_BUBBLE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_RUN;
      branch_q   <= 1'b0;
      alusrc_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      jump_q     <= 1'b0;
      aluop_q    <= 2'b00;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      valid_q    <= 1'b0;
      mul_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      branch_q   <= branch_d;
      alusrc_q   <= alusrc_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      jump_q     <= jump_d;
      aluop_q    <= aluop_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      valid_q    <= valid_d;
      mul_q      <= mul_d;
      cnt_q      <= cnt_d;
    end
  end

  assign branch_o     = branch_q;
  assign alusrc_o     = alusrc_q;
  assign regwrite_o   = regwrite_q;
  assign memread_o    = memread_q;
  assign memwrite_o   = memwrite_q;
  assign memtoreg_o   = memtoreg_q;
  assign jump_o       = jump_q;
  assign aluop_o      = aluop_q;
  assign rs1_o        = rs1_q;
  assign rs2_o        = rs2_q;
  assign rd_o         = rd_q;
  assign valid_o      = valid_q;
  assign mul_o        = mul_q;
  assign bubble_cnt_o = cnt_q;

endmodule
